core_packetizer: RTL

//  Core-side flit source directly upstream of the core interface's from_core_flit/v_from_core inputs.

---
 rtl/core_packetizer_if.sv | 34 +++
 rtl/core_packetizer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/core_packetizer_if.sv
// Request and flit bus between a core-side requester and core_packetizer.
// master = requester / flit consumer side, slave = packetizer.
interface core_packetizer_if #(
   parameter int FLIT_WIDTH  = 32,
   parameter int VC_PER_PORT = 2,
   parameter int VC_BITS     = 1,
   parameter int DATA_FLITS  = 2,
   parameter int DEST_WIDTH  = 8
);
   localparam int PW = FLIT_WIDTH - 2 - VC_BITS;
   // A zero-flit packet still carries one word of (ignored) data so the port never has zero width.
   localparam int DW = (DATA_FLITS > 0) ? DATA_FLITS * PW : PW;

   logic                   req_valid;
   logic                   req_ready;
   logic [DEST_WIDTH-1:0]  req_dest;
   logic [VC_BITS-1:0]     req_vc;
   logic [DW-1:0]          req_data;
   logic                   ren;
   logic [VC_PER_PORT-1:0] from_core_full;
   logic [FLIT_WIDTH-1:0]  to_ci_flit;
   logic                   v_to_ci;
   logic                   busy;

   modport master (
      output req_valid, req_dest, req_vc, req_data, ren, from_core_full,
      input  req_ready, to_ci_flit, v_to_ci, busy
   );

   modport slave (
      input  req_valid, req_dest, req_vc, req_data, ren, from_core_full,
      output req_ready, to_ci_flit, v_to_ci, busy
   );
endinterface

// File: rtl/core_packetizer.sv
// Serialises one packet request into head/body/tail flits on a locked VC.
// Optional feature macro: PKT_SEQ_EN (8-bit packet sequence number in the head flit).
module core_packetizer #(
   parameter int FLIT_WIDTH  = 32,
   parameter int VC_PER_PORT = 2,
   parameter int VC_BITS     = 1,
   parameter int DATA_FLITS  = 2,
   parameter int DEST_WIDTH  = 8,
   parameter int SRC_ID      = 0
) (
   input  logic              clk,
   input  logic              reset,
   core_packetizer_if.slave  bus
);
   localparam int PW    = FLIT_WIDTH - 2 - VC_BITS;
   localparam int DW    = (DATA_FLITS > 0) ? DATA_FLITS * PW : PW;
   localparam int LEN_W = PW - 2 * DEST_WIDTH - 8;
   localparam logic [4:0] LAST_IDX = 5'((DATA_FLITS == 0) ? 0 : DATA_FLITS - 1);
   localparam logic [1:0] HEAD_TYPE = (DATA_FLITS == 0) ? 2'b11 : 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                  state_r;
   logic [DEST_WIDTH-1:0]   dest_r;
   logic [VC_BITS-1:0]      vc_r;
   logic [DW-1:0]           data_r;
   logic [4:0]              cnt_r;
   logic [7:0]              seq_s;
   logic [VC_PER_PORT-1:0]  full_s;
   logic                    busy_s;
   logic                    send_s;
   logic                    last_send_s;
   logic [PW-1:0]           word_s;
   logic [FLIT_WIDTH-1:0]   flit_s;

   assign full_s      = bus.from_core_full;
   assign busy_s      = (state_r != IDLE);
   // Only the full flag of the locked VC can stall the packet.
   assign send_s      = busy_s & bus.ren & ~full_s[vc_r];
   assign last_send_s = send_s & (((state_r == DATA) && (cnt_r == LAST_IDX)) ||
                                  ((state_r == HEAD) && (DATA_FLITS == 0)));

   assign bus.req_ready  = ~busy_s;
   assign bus.busy       = busy_s;
   assign bus.v_to_ci    = send_s;
   assign bus.to_ci_flit = flit_s;

`ifdef PKT_SEQ_EN
   logic [7:0] seq_r;

   // Packet sequence number, advanced once per completed packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_r <= 8'd0;
      end else if (last_send_s) begin
         seq_r <= seq_r + 8'd1;
      end else begin
         seq_r <= seq_r;
      end
   end

   assign seq_s = seq_r;
`else
   assign seq_s = 8'd0;
`endif

   // Select payload word cnt_r from the captured request data.
   always_comb begin
      word_s = '0;
      for (int k = 0; k < DATA_FLITS; k++) begin
         if (cnt_r == 5'(k)) begin
            word_s = data_r[k*PW +: PW];
         end else begin
            word_s = word_s;
         end
      end
   end

   // Assemble the current flit from registered state; zero while idle.
   always_comb begin
      flit_s = '0;
      case (state_r)
         HEAD: flit_s = {HEAD_TYPE, vc_r, dest_r, DEST_WIDTH'(SRC_ID), seq_s,
                         LEN_W'(DATA_FLITS)};
         DATA: flit_s = {((cnt_r == LAST_IDX) ? 2'b10 : 2'b00), vc_r, word_s};
         default: flit_s = '0;
      endcase
   end

   // Packet FSM: capture request in IDLE, walk flits on each send, hold on stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         dest_r  <= '0;
         vc_r    <= '0;
         data_r  <= '0;
         cnt_r   <= 5'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  state_r <= HEAD;
                  dest_r  <= bus.req_dest;
                  vc_r    <= bus.req_vc;
                  data_r  <= bus.req_data;
                  cnt_r   <= 5'd0;
               end else begin
                  state_r <= IDLE;
               end
            end
            HEAD: begin
               if (send_s) begin
                  state_r <= (DATA_FLITS > 0) ? DATA : IDLE;
               end else begin
                  state_r <= HEAD;
               end
            end
            DATA: begin
               if (send_s && (cnt_r == LAST_IDX)) begin
                  state_r <= IDLE;
               end else if (send_s) begin
                  cnt_r <= cnt_r + 5'd1;
               end else begin
                  state_r <= DATA;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end
endmodule
